score_detector: RTL and testbench



---
 rtl/flappy_pkg.sv | 17 +
 rtl/pulse_holdoff.sv | 34 +++
 rtl/score_detector.sv | 133 +++++++++++++
 tb/tb_score_detector.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/flappy_pkg.sv
// Shared Flappy Bird datapath types and default geometry, used by the score
// detector, the pipe generator and the collision logic.
package flappy_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    APPROACH = 3'd1,
    OVERLAP  = 3'd2,
    SPENT    = 3'd3,
    DEAD     = 3'd4
  } score_state_t;

  localparam int DEF_X_W    = 8;
  localparam int DEF_BIRD_X = 16;
  localparam int DEF_PIPE_W = 4;

endpackage

// File: rtl/pulse_holdoff.sv
// Load/decrement down-counter that flags when another score pulse is still
// too close to the previous one. Used only when SCORE_HOLDOFF_EN is defined.
module pulse_holdoff #(
  parameter int HOLDOFF = 8
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic load,
  output logic busy
);

  localparam int CW = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;

  logic [CW-1:0] count_r;

  // Counter: clear wins, a pulse reloads, otherwise count down to zero.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count_r <= {CW{1'b0}};
    end else if (clear) begin
      count_r <= {CW{1'b0}};
    end else if (load) begin
      count_r <= CW'(HOLDOFF - 1);
    end else if (count_r != {CW{1'b0}}) begin
      count_r <= count_r - CW'(1);
    end else begin
      count_r <= count_r;
    end
  end

  assign busy = (count_r != {CW{1'b0}});

endmodule

// File: rtl/score_detector.sv
// Emits one registered score_pulse each time a pipe fully clears the bird.
// Optional macro SCORE_HOLDOFF_EN enforces HOLDOFF cycles between pulses.
module score_detector
  import flappy_pkg::*;
#(
  parameter int X_W     = DEF_X_W,
  parameter int BIRD_X  = DEF_BIRD_X,
  parameter int PIPE_W  = DEF_PIPE_W,
  parameter int HOLDOFF = 8
) (
  input  logic           clock,
  input  logic           reset,
  input  logic           game_active,
  input  logic           crash,
  input  logic [X_W-1:0] pipe_x,
  output logic           score_pulse,
  output logic [7:0]     score_count,
  output logic           dead
);

  if (PIPE_W < 1 || HOLDOFF < 1) begin : g_param_check
    $error("score_detector: PIPE_W and HOLDOFF must both be at least 1");
  end

  score_state_t state_r, next_state_s;
  logic         pulse_s;
  logic         busy_s;
  logic         ahead_s;
  logic         cleared_s;
  logic [X_W:0] pipe_ext_s;
  logic [X_W:0] right_edge_s;
  logic [X_W:0] bird_s;
  logic         score_pulse_r;
  logic [7:0]   score_count_r;
  logic         dead_r;

  // One extra bit keeps the right edge exact at the top of the column range.
  assign pipe_ext_s   = {1'b0, pipe_x};
  assign bird_s       = (X_W + 1)'(BIRD_X);
  assign right_edge_s = pipe_ext_s + (X_W + 1)'(PIPE_W) - (X_W + 1)'(1);
  assign ahead_s      = (pipe_ext_s > bird_s);
  assign cleared_s    = (right_edge_s < bird_s);

`ifdef SCORE_HOLDOFF_EN
  pulse_holdoff #(
    .HOLDOFF(HOLDOFF)
  ) u_holdoff (
    .clock(clock),
    .reset(reset),
    .clear(next_state_s == IDLE),
    .load (pulse_s),
    .busy (busy_s)
  );
`else
  assign busy_s = 1'b0;
`endif

  // Next state and pulse qualification; round end and crash take priority.
  always_comb begin
    next_state_s = state_r;
    pulse_s      = 1'b0;
    if (!game_active) begin
      next_state_s = IDLE;
    end else if (crash) begin
      next_state_s = DEAD;
    end else begin
      case (state_r)
        IDLE: begin
          if (ahead_s) begin
            next_state_s = APPROACH;
          end else begin
            next_state_s = SPENT;
          end
        end
        APPROACH: begin
          if (cleared_s) begin
            next_state_s = SPENT;
            pulse_s      = !busy_s;
          end else if (!ahead_s) begin
            next_state_s = OVERLAP;
          end else begin
            next_state_s = APPROACH;
          end
        end
        OVERLAP: begin
          if (cleared_s) begin
            next_state_s = SPENT;
            pulse_s      = !busy_s;
          end else if (ahead_s) begin
            next_state_s = APPROACH;
          end else begin
            next_state_s = OVERLAP;
          end
        end
        SPENT: begin
          if (ahead_s) begin
            next_state_s = APPROACH;
          end else begin
            next_state_s = SPENT;
          end
        end
        DEAD:    next_state_s = DEAD;
        default: next_state_s = IDLE;
      endcase
    end
  end

  // State and registered outputs; the count is zeroed whenever IDLE is entered.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r       <= IDLE;
      score_pulse_r <= 1'b0;
      score_count_r <= 8'd0;
      dead_r        <= 1'b0;
    end else begin
      state_r       <= next_state_s;
      score_pulse_r <= pulse_s;
      dead_r        <= (next_state_s == DEAD);
      if (next_state_s == IDLE) begin
        score_count_r <= 8'd0;
      end else if (pulse_s) begin
        score_count_r <= score_count_r + 8'd1;
      end else begin
        score_count_r <= score_count_r;
      end
    end
  end

  assign score_pulse = score_pulse_r;
  assign score_count = score_count_r;
  assign dead        = dead_r;

endmodule

// File: tb/tb_score_detector.sv
// Self-checking bench for score_detector: directed scenarios plus a random
// walk, all compared against a pipe-level "armed until cleared" model.
module tb_score_detector;

  localparam int HOLDOFF = 8;
  localparam int BIRD    = 16;
  localparam int PW      = 4;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       game_active = 1'b0;
  logic       crash = 1'b0;
  logic [7:0] pipe_x = 8'd0;
  logic       score_pulse;
  logic [7:0] score_count;
  logic       dead;

  int n_cmp = 0;
  int n_bad = 0;

  // reference model state
  bit m_active, m_armed, m_dead, m_pulse;
  int m_count, m_hold;
  int pulses_seen, pulse_px;

  always #5 clock = ~clock;

  score_detector #(
    .X_W(8), .BIRD_X(BIRD), .PIPE_W(PW), .HOLDOFF(HOLDOFF)
  ) dut (
    .clock(clock), .reset(reset), .game_active(game_active), .crash(crash),
    .pipe_x(pipe_x), .score_pulse(score_pulse), .score_count(score_count), .dead(dead)
  );

  task automatic model_reset();
    m_active = 0; m_armed = 0; m_dead = 0; m_pulse = 0; m_count = 0; m_hold = 0;
  endtask

  // A pipe is armed once seen ahead of the bird; it scores when it clears while armed.
  task automatic model_step(input logic ga, input logic cr, input logic [7:0] px);
    bit ahead, clr, busy;
    ahead = (int'(px) > BIRD);
    clr   = (int'(px) + PW - 1 < BIRD);
    busy  = (m_hold != 0);
    m_pulse = 0;
    if (!ga) begin
      m_active = 0; m_dead = 0; m_count = 0;
    end else if (m_dead) begin
    end else if (cr) begin
      m_dead = 1;
    end else if (!m_active) begin
      m_active = 1; m_armed = ahead;
    end else if (ahead) begin
      m_armed = 1;
    end else if (clr && m_armed) begin
      m_armed = 0;
      if (!busy) begin
        m_pulse = 1; m_count = (m_count + 1) % 256;
      end
    end
`ifdef SCORE_HOLDOFF_EN
    if (!ga) m_hold = 0;
    else if (m_pulse) m_hold = HOLDOFF - 1;
    else if (m_hold > 0) m_hold--;
`endif
  endtask

  task automatic tick(input logic ga, input logic cr, input logic [7:0] px);
    game_active = ga; crash = cr; pipe_x = px;
    @(posedge clock);
    model_step(ga, cr, px);
    #1;
    if (score_pulse === 1'b1) begin
      pulses_seen++; pulse_px = int'(px);
    end
  endtask

  task automatic sweep(input string tag, input int from, input bit crash_at12);
    for (int px = from; px >= 0; px--) begin
      tick(1'b1, crash_at12 && (px == 12), 8'(px));
      n_cmp++;
      if ({score_pulse, score_count, dead} !== {m_pulse, 8'(m_count), m_dead}) begin
        n_bad++;
        $display("FAIL %s px=%0d: got pulse=%b count=%0d dead=%b, want pulse=%b count=%0d dead=%b",
                 tag, px, score_pulse, score_count, dead, m_pulse, m_count, m_dead);
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; model_reset();
    #13;
    n_cmp++;
    if ({score_pulse, score_count, dead} !== 10'd0) begin
      n_bad++;
      $display("FAIL reset_state: got pulse=%b count=%0d dead=%b, want all 0", score_pulse, score_count, dead);
    end
    @(negedge clock); reset = 1'b1;
  endtask

  task automatic test_normal_pass();
    tick(1'b0, 1'b0, 8'd40);
    pulses_seen = 0; pulse_px = -1;
    sweep("normal", 40, 1'b0);
    n_cmp++;
    if (pulses_seen != 1 || pulse_px != 12 || score_count !== 8'd1) begin
      n_bad++;
      $display("FAIL normal_pass: got pulses=%0d at_px=%0d count=%0d, want 1 at 12 count=1",
               pulses_seen, pulse_px, score_count);
    end
  endtask

  task automatic test_multi_pipe();
    sweep("multi", 40, 1'b0);
    sweep("multi", 40, 1'b0);
    n_cmp++;
    if (score_count !== 8'd3) begin
      n_bad++; $display("FAIL multi_three: got count=%0d, want 3", score_count);
    end
    for (int s = 3; s < 256; s++) sweep("wrap", 40, 1'b0);
    n_cmp++;
    if (score_count !== 8'd0) begin
      n_bad++; $display("FAIL multi_wrap: got count=%0d, want 0", score_count);
    end
  endtask

  task automatic test_crash();
    tick(1'b0, 1'b0, 8'd40);
    pulses_seen = 0;
    sweep("crash", 40, 1'b1);
    sweep("crash_after", 40, 1'b0);
    n_cmp++;
    if (pulses_seen != 0 || dead !== 1'b1 || score_count !== 8'd0) begin
      n_bad++;
      $display("FAIL crash: got pulses=%0d dead=%b count=%0d, want 0 1 0", pulses_seen, dead, score_count);
    end
    tick(1'b0, 1'b0, 8'd40);
    tick(1'b1, 1'b0, 8'd40);
    n_cmp++;
    if (dead !== 1'b0 || score_count !== 8'd0) begin
      n_bad++; $display("FAIL crash_recover: got dead=%b count=%0d, want 0 0", dead, score_count);
    end
  endtask

  task automatic test_midstart_skip();
    tick(1'b0, 1'b0, 8'd14);
    pulses_seen = 0;
    sweep("midstart", 14, 1'b0);
    n_cmp++;
    if (pulses_seen != 0) begin
      n_bad++; $display("FAIL midstart: got pulses=%0d, want 0", pulses_seen);
    end
    tick(1'b1, 1'b0, 8'd20);
    tick(1'b1, 1'b0, 8'd5);
    n_cmp++;
    if (score_pulse !== 1'b1 || score_count !== 8'd1) begin
      n_bad++; $display("FAIL skip: got pulse=%b count=%0d, want 1 1", score_pulse, score_count);
    end
  endtask

  task automatic test_async_reset();
    tick(1'b0, 1'b0, 8'd40);
    for (int px = 40; px >= 12; px--) tick(1'b1, 1'b0, 8'(px));
    n_cmp++;
    if (score_pulse !== 1'b1) begin
      n_bad++; $display("FAIL async_pre: got pulse=%b, want 1", score_pulse);
    end
    #2 reset = 1'b0;
    #1;
    n_cmp++;
    if (score_pulse !== 1'b0 || score_count !== 8'd0 || dead !== 1'b0) begin
      n_bad++; $display("FAIL async_reset: got pulse=%b count=%0d dead=%b, want 0 0 0", score_pulse, score_count, dead);
    end
    model_reset();
    @(negedge clock); reset = 1'b1;
  endtask

  task automatic test_back_to_back();
    bit want_second;
`ifdef SCORE_HOLDOFF_EN
    want_second = 0;
`else
    want_second = 1;
`endif
    tick(1'b0, 1'b0, 8'd40);
    tick(1'b1, 1'b0, 8'd20);
    tick(1'b1, 1'b0, 8'd5);
    for (int i = 0; i < 4; i++) tick(1'b1, 1'b0, 8'd20);
    tick(1'b1, 1'b0, 8'd5);
    n_cmp++;
    if (score_pulse !== want_second || score_pulse !== m_pulse) begin
      n_bad++; $display("FAIL clear_after_5: got pulse=%b, want %b", score_pulse, want_second);
    end
    for (int i = 0; i < 3; i++) tick(1'b1, 1'b0, 8'd20);
    tick(1'b1, 1'b0, 8'd5);
    n_cmp++;
    if (score_pulse !== 1'b1 || score_count !== 8'(m_count)) begin
      n_bad++; $display("FAIL clear_after_9: got pulse=%b count=%0d, want 1 %0d", score_pulse, score_count, m_count);
    end
  endtask

  task automatic test_random();
    int px;
    logic ga, cr;
    px = 60;
    for (int c = 0; c < 4000; c++) begin
      ga = ($urandom_range(0, 99) >= 2);
      cr = ($urandom_range(0, 199) == 0);
      if (px < 3 || $urandom_range(0, 49) == 0) px = $urandom_range(17, 255);
      else px = px - $urandom_range(1, ($urandom_range(0, 9) == 0) ? 12 : 2);
      if (px < 0) px = 0;
      tick(ga, cr, 8'(px));
      n_cmp++;
      if ({score_pulse, score_count, dead} !== {m_pulse, 8'(m_count), m_dead}) begin
        n_bad++;
        $display("FAIL random c=%0d px=%0d: got pulse=%b count=%0d dead=%b, want pulse=%b count=%0d dead=%b",
                 c, px, score_pulse, score_count, dead, m_pulse, m_count, m_dead);
      end
    end
  endtask

  initial begin
    test_reset();
    test_normal_pass();
    test_multi_pipe();
    test_crash();
    test_midstart_skip();
    test_async_reset();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
